// File: rtl/icache_assoc_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_assoc_pkg;

  typedef enum logic {IDLE, FILL} icache_state_t;

  function automatic int iidx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int iwoff_w(input int blkwords);
    return $clog2(blkwords);
  endfunction

  function automatic int itag_w(input int sets, input int blkwords);
    return 30 - $clog2(sets) - $clog2(blkwords);
  endfunction

  localparam int ISETS     = 8;
  localparam int IBLKWORDS = 2;
  localparam int IIDX_W    = iidx_w(ISETS);
  localparam int IWOFF_W   = iwoff_w(IBLKWORDS);
  localparam int ITAG_W    = itag_w(ISETS, IBLKWORDS);

  typedef struct packed {
    logic [ITAG_W-1:0]  tag;
    logic [IIDX_W-1:0]  idx;
    logic [IWOFF_W-1:0] woff;
    logic [1:0]         bytoff;
  } icache_addr_t;

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave  (input imemREN, imemaddr, iflush, iwait, iload,
                  output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iflush, iwait, iload,
                  input ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_way.sv
// One cache way: valid/tag/data storage with a combinational read port at ridx.
module icache_way import icache_assoc_pkg::*; #(
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2,
  parameter int TAG_W    = 26,
  parameter int IDX_W    = iidx_w(SETS),
  parameter int K_W      = (iwoff_w(BLKWORDS) > 0) ? iwoff_w(BLKWORDS) : 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     flush,
  input  logic [IDX_W-1:0]         ridx,
  output logic                     rvalid,
  output logic [TAG_W-1:0]         rtag,
  output logic [BLKWORDS-1:0][31:0] rdata,
  input  logic [IDX_W-1:0]         widx,
  input  logic [K_W-1:0]           wwoff,
  input  logic                     we_word,
  input  logic [31:0]              wdata,
  input  logic                     we_tag,
  input  logic [TAG_W-1:0]         wtag
);
  logic [SETS-1:0]          valid;
  logic [TAG_W-1:0]         tags [SETS];
  logic [BLKWORDS-1:0][31:0] data [SETS];

  // Flush has priority so a fill finishing in the flush cycle stays invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        valid <= '0;
    else if (flush)   valid <= '0;
    else if (we_tag)  valid[widx] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (we_tag)  tags[widx] <= wtag;
    if (we_word) data[widx][wwoff] <= wdata;
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];
endmodule

// File: rtl/icache_assoc.sv
// Set-associative icache: fill FSM, round-robin victim pointers, hit mux.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_assoc import icache_assoc_pkg::*; #(
  parameter int WAYS     = 2,
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2
) (
  input logic           CLK,
  input logic           nRST,
  icache_assoc_if.slave cif
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);
  localparam int IDX_W  = iidx_w(SETS);
  localparam int WOFF_W = iwoff_w(BLKWORDS);
  localparam int TAG_W  = itag_w(SETS, BLKWORDS);
  localparam int K_W    = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  icache_state_t state_q, state_d;
  logic [TAG_W-1:0]  tag_a, tag_q;
  logic [IDX_W-1:0]  idx_a, idx_q;
  logic [K_W-1:0]    woff_a, k_q;
  logic [WAY_W-1:0]  way_q, victim;
  logic [WAY_W-1:0]  vptr [SETS];
  logic [WAYS-1:0]   rvalid, hit_w, we_word, we_tag;
  logic [TAG_W-1:0]  rtag [WAYS];
  logic [BLKWORDS-1:0][31:0] rdata [WAYS];
  logic [31:0]       load;
  logic              last_word, fill_step, start_fill, found;

  assign woff_a = K_W'((cif.imemaddr >> 2) & 32'(BLKWORDS - 1));
  assign idx_a  = IDX_W'(cif.imemaddr >> (2 + WOFF_W));
  assign tag_a  = TAG_W'(cif.imemaddr >> (2 + WOFF_W + IDX_W));

  assign last_word = (k_q == K_W'(BLKWORDS - 1));
  assign fill_step = (state_q == FILL) && !cif.iwait;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign we_word[w] = fill_step && (way_q == WAY_W'(w));
    assign we_tag[w]  = fill_step && last_word && !cif.iflush && (way_q == WAY_W'(w));

    icache_way #(.SETS(SETS), .BLKWORDS(BLKWORDS), .TAG_W(TAG_W)) u_way (
      .CLK(CLK), .nRST(nRST), .flush(cif.iflush),
      .ridx(idx_a), .rvalid(rvalid[w]), .rtag(rtag[w]), .rdata(rdata[w]),
      .widx(idx_q), .wwoff(k_q), .we_word(we_word[w]), .wdata(cif.iload),
      .we_tag(we_tag[w]), .wtag(tag_q)
    );
  end

  always_comb begin
    hit_w  = '0;
    load   = '0;
    victim = vptr[idx_a];
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (rvalid[w] && (rtag[w] == tag_a)) begin
        hit_w[w] = 1'b1;
        load     = rdata[w][woff_a];
      end
      if (!found && !rvalid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    start_fill   = 1'b0;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    case (state_q)
      IDLE: begin
        if (cif.imemREN && !cif.iflush) begin
          if (|hit_w) begin
            cif.ihit     = 1'b1;
            cif.imemload = load;
          end else begin
            state_d    = FILL;
            start_fill = 1'b1;
          end
        end
      end
      FILL: begin
        cif.iREN  = 1'b1;
        cif.iaddr = (32'({tag_q, idx_q}) << (WOFF_W + 2)) | (32'(k_q) << 2);
        if (!cif.iwait && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cif.iflush) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tag_q <= '0;
      idx_q <= '0;
      way_q <= '0;
      k_q   <= '0;
    end else if (start_fill) begin
      tag_q <= tag_a;
      idx_q <= idx_a;
      way_q <= victim;
      k_q   <= '0;
    end else if (fill_step) begin
      k_q <= last_word ? '0 : k_q + 1'b1;
    end
  end

  // Pointer advances on every completed fill, even when an invalid way was chosen.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else if (cif.iflush) begin
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else if (fill_step && last_word) begin
      vptr[idx_q] <= (WAYS == 1) ? '0 : vptr[idx_q] + 1'b1;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cif.ihit)  hit_cnt  <= hit_cnt + 32'd1;
      if (start_fill) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Directed and random fetch sequences for icache_assoc, checked against a line-level model.
module tb_icache_assoc;
  localparam int WAYS = 2, SETS = 8, BLKWORDS = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  icache_assoc_if bus();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLKWORDS(BLKWORDS)) dut (
    .CLK(CLK), .nRST(nRST), .cif(bus)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  bit          mvalid [WAYS][SETS];
  logic [31:0] mtag   [WAYS][SETS];
  int          mvptr  [SETS];
  int n_assert = 0, n_fail = 0, exp_hits = 0, exp_misses = 0;

  function automatic logic [31:0] memword(input logic [31:0] waddr);
    return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / (4 * BLKWORDS)) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * BLKWORDS * SETS);
  endfunction

  function automatic int lookup(input logic [31:0] a);
    int r = -1;
    for (int w = 0; w < WAYS; w++)
      if (mvalid[w][set_of(a)] && mtag[w][set_of(a)] == tag_of(a)) r = w;
    return r;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++) begin
      mvptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mvalid[w][s] = 1'b0;
    end
  endfunction

  function automatic void model_install(input logic [31:0] a);
    int s = set_of(a);
    int v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!mvalid[w][s]) v = w;
    if (v < 0) v = mvptr[s];
    mvalid[v][s] = 1'b1;
    mtag[v][s]   = tag_of(a);
    mvptr[s]     = (mvptr[s] + 1) % WAYS;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One fetch; on a miss, runs the fill (optionally flushed at word flush_word,
  // optionally with imemaddr moved to alt during the fill), then refetches.
  task automatic fetch(input logic [31:0] a, input int wait_pct, input int flush_word,
                       input logic [31:0] alt);
    int k, budget;
    logic [31:0] wa;
    bus.imemREN = 1'b1; bus.imemaddr = a; bus.iflush = 1'b0; bus.iwait = 1'b0;
    @(negedge CLK);
    if (lookup(a) >= 0) begin
      check("hit", bus.ihit, 1);
      check("hit_data", bus.imemload, memword(a >> 2));
      check("hit_iren", bus.iREN, 0);
      exp_hits++;
      tick();
      return;
    end
    check("miss_ihit", bus.ihit, 0);
    check("miss_iren", bus.iREN, 0);
    exp_misses++;
    tick();
    bus.imemaddr = alt;
    k = 0; budget = 0;
    while (k < BLKWORDS) begin
      bus.iwait  = ($urandom_range(99) < wait_pct);
      bus.iflush = (k == flush_word);
      if (bus.iflush) bus.iwait = 1'b0;
      wa = (a & ~32'(4 * BLKWORDS - 1)) + 32'(4 * k);
      bus.iload = memword(wa >> 2);
      @(negedge CLK);
      check("fill_iren", bus.iREN, 1);
      check("fill_iaddr", bus.iaddr, wa);
      check("fill_ihit", bus.ihit, 0);
      if (bus.iflush) begin
        tick();
        bus.iflush = 1'b0;
        model_flush();
        return;
      end
      if (!bus.iwait) k++;
      tick();
      budget++;
      if (budget > 500) begin
        check("fill_budget", 32'(budget), 32'(500));
        return;
      end
    end
    bus.iwait = 1'b0;
    model_install(a);
    bus.imemaddr = a;
    @(negedge CLK);
    check("refetch_hit", bus.ihit, 1);
    check("refetch_data", bus.imemload, memword(a >> 2));
    exp_hits++;
    tick();
  endtask

  initial begin
    logic [31:0] a;
    int r;
    model_flush();
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iflush = 1'b0;
    bus.iwait = 1'b0; bus.iload = '0;
    #12;
    check("rst_ihit", bus.ihit, 0);
    check("rst_iren", bus.iREN, 0);
    check("rst_iaddr", bus.iaddr, 0);
    check("rst_imemload", bus.imemload, 0);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    check("idle_iren", bus.iREN, 0);
    tick();

    // cold miss then same-block hit
    fetch(32'h40, 0, -1, 32'h40);
    fetch(32'h44, 0, -1, 32'h44);

    // three tags on one set: 0x40 gets evicted
    fetch(32'h140, 0, -1, 32'h140);
    fetch(32'h240, 0, -1, 32'h240);
    fetch(32'h140, 0, -1, 32'h140);
    fetch(32'h40, 0, -1, 32'h40);

    // five wait cycles per word: twelve fill cycles
    bus.imemREN = 1'b1; bus.imemaddr = 32'h108;
    @(negedge CLK);
    check("t3_miss", bus.ihit, 0);
    exp_misses++;
    tick();
    for (int k = 0; k < BLKWORDS; k++) begin
      for (int c = 0; c < 6; c++) begin
        bus.iwait = (c < 5);
        bus.iload = memword((32'h108 + 32'(4 * k)) >> 2);
        @(negedge CLK);
        check("t3_iaddr", bus.iaddr, 32'h108 + 32'(4 * k));
        check("t3_iren", bus.iREN, 1);
        check("t3_ihit", bus.ihit, 0);
        tick();
      end
    end
    bus.iwait = 1'b0;
    model_install(32'h108);
    @(negedge CLK);
    check("t3_done_hit", bus.ihit, 1);
    check("t3_done_data", bus.imemload, memword(32'h108 >> 2));
    exp_hits++;
    tick();

    // flush on the last fill word wins; earlier lines all miss afterwards
    fetch(32'h340, 0, 1, 32'h340);
    fetch(32'h140, 0, -1, 32'h140);
    fetch(32'h108, 0, -1, 32'h108);
    fetch(32'h40, 0, -1, 32'h40);

    // flush in IDLE on a hitting address suppresses ihit
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iflush = 1'b1;
    @(negedge CLK);
    check("flush_ihit", bus.ihit, 0);
    check("flush_iren", bus.iREN, 0);
    tick();
    bus.iflush = 1'b0;
    model_flush();

    // no request: nothing happens
    bus.imemREN = 1'b0; bus.imemaddr = 32'h44;
    @(negedge CLK);
    check("noreq_ihit", bus.ihit, 0);
    tick();
    @(negedge CLK);
    check("noreq_iren", bus.iREN, 0);
    tick();

    // reset during a fill discards everything
    bus.imemREN = 1'b1; bus.imemaddr = 32'h200;
    @(negedge CLK);
    tick();
    bus.iwait = 1'b1; bus.imemREN = 1'b0;
    @(negedge CLK);
    check("rstfill_iren_pre", bus.iREN, 1);
    nRST = 1'b0;
    #1;
    check("rstfill_iren", bus.iREN, 0);
    check("rstfill_iaddr", bus.iaddr, 0);
    tick();
    nRST = 1'b1; bus.iwait = 1'b0;
    model_flush();
    exp_hits = 0; exp_misses = 0;

    // imemaddr moved mid-fill does not redirect the fill
    fetch(32'h40, 0, -1, 32'h80);
    fetch(32'h80, 0, -1, 32'h80);
    fetch(32'h40, 0, -1, 32'h40);
    fetch(32'h200, 0, -1, 32'h200);

    for (int i = 0; i < 120; i++) begin
      a = ($urandom_range(3) << 6) | ($urandom_range(7) << 3) |
          ($urandom_range(1) << 2) | $urandom_range(3);
      r = $urandom_range(15);
      if (r == 0) begin
        bus.imemREN = 1'b1; bus.imemaddr = a; bus.iflush = 1'b1;
        @(negedge CLK);
        check("rnd_flush_ihit", bus.ihit, 0);
        tick();
        bus.iflush = 1'b0;
        model_flush();
      end else if (r == 1) begin
        bus.imemREN = 1'b0; bus.imemaddr = a;
        @(negedge CLK);
        check("rnd_idle_ihit", bus.ihit, 0);
        check("rnd_idle_iren", bus.iREN, 0);
        tick();
      end else begin
        fetch(a, 30, (r == 2) ? int'($urandom_range(BLKWORDS - 1)) : -1, a);
      end
    end
    bus.imemREN = 1'b0;

`ifdef ICACHE_PERF_EN
    @(negedge CLK);
    check("perf_hits", hit_cnt, 32'(exp_hits));
    check("perf_misses", miss_cnt, 32'(exp_misses));
    nRST = 1'b0;
    #1;
    check("perf_hits_rst", hit_cnt, 0);
    check("perf_misses_rst", miss_cnt, 0);
    tick();
    nRST = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
